// File: rtl/riscv_muldiv.sv
// riscv_muldiv: iterative RV32M multiply/divide unit computing one bit per cycle.
// Divide-by-zero and signed division overflow bypass the iteration and finish in one cycle.
module riscv_muldiv #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        funct3,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   localparam int ACC_W = 2*DATA_W + 1;
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] ALL_ONES = '1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_rem_q, neg_rem_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] result_q, result_d;

   logic              is_div, signed_a, signed_b, a_neg, b_neg, div_zero, div_ovf;
   logic [DATA_W-1:0] a_abs, b_abs, fast_res;

   // Decode the request on the inputs: signedness, magnitudes and the fast-path result.
   always_comb begin
      is_div   = funct3[2];
      signed_a = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
      signed_b = is_div ? ~funct3[0] : ~funct3[1];
      a_neg    = signed_a & op_a[DATA_W-1];
      b_neg    = signed_b & op_b[DATA_W-1];
      a_abs    = a_neg ? -op_a : op_a;
      b_abs    = b_neg ? -op_b : op_b;
      div_zero = is_div && (op_b == '0);
      div_ovf  = is_div && !funct3[0] && (op_a == MIN_NEG) && (op_b == ALL_ONES);
      if (div_zero) begin
         fast_res = funct3[1] ? op_a : ALL_ONES;
      end else begin
         fast_res = funct3[1] ? '0 : MIN_NEG;
      end
   end

   logic [ACC_W-1:0]    acc_sh;
   logic [DATA_W:0]     div_ext, rem_try;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quo_fix, rem_fix;

   // The accumulator holds the running product, or {remainder, dividend/quotient} for divides.
   always_comb begin
      acc_sh   = acc_q << 1;
      div_ext  = {1'b0, b_q};
      rem_try  = acc_sh[ACC_W-1:DATA_W] - div_ext;
      prod_fix = neg_res_q ? -acc_q[2*DATA_W-1:0] : acc_q[2*DATA_W-1:0];
      quo_fix  = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
      rem_fix  = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      acc_d     = acc_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      result_d  = result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d      = funct3;
               a_d       = a_abs;
               b_d       = b_abs;
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               cnt_d     = CNT_W'(DATA_W-1);
               acc_d     = is_div ? ACC_W'(a_abs) : '0;
               if (div_zero || div_ovf) begin
                  state_d  = DONE;
                  done_d   = 1'b1;
                  result_d = fast_res;
               end else begin
                  state_d = CALC;
                  busy_d  = 1'b1;
               end
            end
         end
         CALC: begin
            if (op_q[2]) begin
               if (acc_sh[ACC_W-1:DATA_W] >= div_ext) begin
                  acc_d = {rem_try, acc_sh[DATA_W-1:1], 1'b1};
               end else begin
                  acc_d = acc_sh;
               end
            end else begin
               acc_d = acc_sh + (b_q[cnt_q] ? ACC_W'(a_q) : '0);
            end
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         FIX: begin
            case (op_q)
               3'b000:                 result_d = prod_fix[DATA_W-1:0];
               3'b001, 3'b010, 3'b011: result_d = prod_fix[2*DATA_W-1:DATA_W];
               3'b100, 3'b101:         result_d = quo_fix;
               default:                result_d = rem_fix;
            endcase
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // A squash abandons the operation without touching the last delivered result.
      if (flush) begin
         state_d  = IDLE;
         busy_d   = 1'b0;
         done_d   = 1'b0;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         acc_q     <= acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// tb_riscv_muldiv: scoreboard bench for riscv_muldiv at DATA_W = 32.
// Expected results are queued when an operation is started and popped when done pulses.
module tb_riscv_muldiv;

   localparam int DATA_W   = 32;
   localparam int NORM_LAT = DATA_W + 2;
   localparam logic [31:0] MIN_NEG  = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [2:0]        funct3;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              flush;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] result;

   riscv_muldiv #(.DATA_W(DATA_W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      int          startCyc;
      int          lat;
   } expEntry_t;

   expEntry_t   scoreboard[$];
   string       tagQ[$];
   int          cyc      = 0;
   int          checkCnt = 0;
   int          passCnt  = 0;
   int          doneCnt  = 0;
   logic [31:0] lastRes  = '0;
   expEntry_t   monEntry;
   string       monTag;

   always @(posedge clk) cyc <= cyc + 1;

   // Single point of comparison: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCnt++;
      if (observed === expected) begin
         passCnt++;
      end else begin
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference model built on native 64-bit arithmetic rather than iteration.
   function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic [63:0]        ua, ub, p;
      logic               ovf;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ovf = (a == MIN_NEG) && (b == ALL_ONES);
      p   = '0;
      case (f)
         3'b000, 3'b001: p = sa * sb;
         3'b010:         p = sa * $signed(ub);
         3'b011:         p = ua * ub;
         3'b100: begin
            if (b == 0) p = '1;
            else if (ovf) p = ua;
            else p = sa / sb;
         end
         3'b101: begin
            if (b == 0) p = '1;
            else p = ua / ub;
         end
         3'b110: begin
            if (b == 0) p = ua;
            else if (ovf) p = '0;
            else p = sa % sb;
         end
         default: begin
            if (b == 0) p = ua;
            else p = ua % ub;
         end
      endcase
      if (f[2] || f == 3'b000) return p[31:0];
      return p[63:32];
   endfunction

   function automatic logic isFast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && ((b == 0) || (!f[0] && a == MIN_NEG && b == ALL_ONES));
   endfunction

   // Retire one expected result per done pulse.
   always @(negedge clk) begin
      if (!reset && done) begin
         doneCnt++;
         if (scoreboard.size() == 0) begin
            checkOutput("unexpected_done", 64'(done), 64'd0);
         end else begin
            monEntry = scoreboard.pop_front();
            monTag   = tagQ.pop_front();
            checkOutput({monTag, "_result"}, 64'(result), 64'(monEntry.res));
            checkOutput({monTag, "_latency"}, 64'(cyc - monEntry.startCyc), 64'(monEntry.lat));
            lastRes = monEntry.res;
         end
      end
   end

   task automatic pushExpect(input logic [31:0] res, input int lat, input string tag);
      expEntry_t e;
      e.res      = res;
      e.startCyc = cyc;
      e.lat      = lat;
      scoreboard.push_back(e);
      tagQ.push_back(tag);
   endtask

   task automatic pulseStart(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      funct3 = f;
      op_a   = a;
      op_b   = b;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
   endtask

   task automatic waitUntil(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Start one operation, wait (bounded) for its done, and check how long busy was high.
   task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expRes, input string tag);
      int lat;
      int busyCycles;
      lat = isFast(f, a, b) ? 1 : NORM_LAT;
      pushExpect(expRes, lat, tag);
      pulseStart(f, a, b);
      busyCycles = 0;
      for (int i = 0; i < NORM_LAT + 8 && scoreboard.size() != 0; i++) begin
         @(negedge clk);
         busyCycles += int'(busy);
         @(posedge clk);
         #1;
      end
      checkOutput({tag, "_pending"}, 64'(scoreboard.size()), 64'd0);
      checkOutput({tag, "_busy_cycles"}, 64'(busyCycles), 64'(lat == 1 ? 0 : DATA_W + 1));
      scoreboard.delete();
      tagQ.delete();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          base;
      int          s;
      logic [2:0]  rf;
      logic [31:0] ra, rb;

      reset  = 1'b1;
      start  = 1'b0;
      flush  = 1'b0;
      funct3 = '0;
      op_a   = '0;
      op_b   = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      checkOutput("reset_result", 64'(result), 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3");
      applyStimulus(3'b011, ALL_ONES, ALL_ONES, 32'hFFFF_FFFE, "mulhu_max");
      applyStimulus(3'b001, MIN_NEG, MIN_NEG, 32'h4000_0000, "mulh_min");
      applyStimulus(3'b010, ALL_ONES, 32'd2, 32'hFFFF_FFFF, "mulhsu");
      applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_-7/2");
      applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_-7/2");
      applyStimulus(3'b101, 32'd100, 32'd7, 32'd14, "divu_100/7");
      applyStimulus(3'b111, 32'd100, 32'd7, 32'd2, "remu_100/7");
      applyStimulus(3'b101, 32'd5, 32'd0, ALL_ONES, "divu_by0");
      applyStimulus(3'b110, 32'd5, 32'd0, 32'd5, "rem_by0");
      applyStimulus(3'b100, MIN_NEG, ALL_ONES, MIN_NEG, "div_ovf");
      applyStimulus(3'b110, MIN_NEG, ALL_ONES, 32'd0, "rem_ovf");

      // Starts during CALC and during DONE must be dropped.
      base = doneCnt;
      s    = cyc;
      pushExpect(32'hFFFF_FFEB, NORM_LAT, "busy_mul");
      pulseStart(3'b000, 32'd7, 32'hFFFF_FFFD);
      waitUntil(s + 5);
      pulseStart(3'b101, 32'd1, 32'd0);
      waitUntil(s + 34);
      pulseStart(3'b011, ALL_ONES, ALL_ONES);
      checkOutput("ignored_start_done_count", 64'(doneCnt - base), 64'd1);
      checkOutput("ignored_start_cycle", 64'(cyc - s), 64'd35);
      applyStimulus(3'b111, 32'd1000, 32'd9, 32'd1, "accept_after_done");

      // Flush in cycle 10 of a running operation.
      base = doneCnt;
      s    = cyc;
      pulseStart(3'b000, 32'd3, 32'd5);
      waitUntil(s + 10);
      checkOutput("flush_busy_before", 64'(busy), 64'd1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkOutput("flush_busy_after", 64'(busy), 64'd0);
      waitUntil(s + 45);
      checkOutput("flush_done_count", 64'(doneCnt - base), 64'd0);
      checkOutput("flush_result_held", 64'(result), 64'(lastRes));

      // Flush and start together in IDLE: start is dropped even on the fast path.
      base   = doneCnt;
      funct3 = 3'b101;
      op_a   = 32'd5;
      op_b   = 32'd0;
      start  = 1'b1;
      flush  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      flush  = 1'b0;
      checkOutput("flush_start_done", 64'(done), 64'd0);
      checkOutput("flush_start_busy", 64'(busy), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("flush_start_done_count", 64'(doneCnt - base), 64'd0);

      // Asynchronous reset in the middle of CALC.
      applyStimulus(3'b011, 32'd12345, 32'd678, refModel(3'b011, 32'd12345, 32'd678), "pre_reset");
      applyStimulus(3'b000, 32'd12345, 32'd678, 32'd8_369_910, "mul_nonzero");
      s = cyc;
      pulseStart(3'b100, 32'd1000, 32'd3);
      waitUntil(s + 8);
      reset = 1'b1;
      #1;
      checkOutput("midreset_busy", 64'(busy), 64'd0);
      checkOutput("midreset_done", 64'(done), 64'd0);
      checkOutput("midreset_result", 64'(result), 64'd0);
      #1;
      reset   = 1'b0;
      lastRes = '0;
      @(posedge clk);
      #1;
      applyStimulus(3'b101, 32'd100, 32'd7, 32'd14, "post_reset_divu");

      for (int i = 0; i < 10; i++) begin
         rf = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = (i == 9) ? 32'd0 : $urandom;
         applyStimulus(rf, ra, rb, refModel(rf, ra, rb), "rand");
      end

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule

// File: doc/riscv_muldiv.md
# riscv_muldiv

Iterative multiply/divide unit that adds the RV32M instruction group to the pipelined RISC-V core. It sits beside the ALU in the execute stage and holds the pipeline through `busy` while it computes. It computes one bit per cycle. Operand width is parametrised, and divide-by-zero and signed overflow take a single-cycle fast path.

## Interface
- `DATA_W`, 32, operand and result width; even, ≥ 4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `funct3`  in  3  operation code:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `op_a`  in  DATA_W  rs1 value (multiplicand or dividend).
- `op_b`  in  DATA_W  rs2 value (multiplier or divisor).
- `flush`  in  1  synchronous abort (branch or jump squash).
- `busy`  out  1  high in CALC and FIX; the pipeline stalls on it.
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  DATA_W  result; held until the next `done`.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - On `start`, latch `funct3`, `op_a` and `op_b`.
  - Take absolute values of the operands per signedness:
    - MUL, MULH: both operands signed.
    - MULHSU: `op_a` signed, `op_b` unsigned.
    - MULHU, DIVU, REMU: both unsigned.
    - DIV, REM: both signed.
  - Record the result sign.
  - Go to CALC, or to DONE on the fast path.
- Fast path (IDLE → DONE directly):
  - Divide ops with `op_b` = 0: DIV and DIVU give all-ones; REM and REMU give `op_a`.
  - DIV or REM with `op_a` = 2^(DATA_W-1) and `op_b` = all-ones: DIV gives 2^(DATA_W-1); REM gives 0.
- CALC:
  - Multiply: shift-add into a 2·DATA_W accumulator.
  - Divide: restoring division, one quotient bit per cycle.
  - Bit counter runs from DATA_W-1 down to 0; at 0 go to FIX.
- FIX:
  - Apply two's-complement negation to the 2·DATA_W product or to the quotient/remainder as required.
  - Remainder takes the sign of the dividend.
  - Select the output: low half for MUL; high half for MULH, MULHSU and MULHU; quotient or remainder for divides.
  - Register the selection into `result`, then go to DONE.
- DONE: `done` = 1 for exactly one cycle; next state is IDLE.
- `start` in any state other than IDLE is ignored; there is no queueing.
- `flush`:
  - In any state, go to IDLE at the next edge.
  - No `done` is produced; `result` keeps its previous value.
  - `flush` and `start` together in IDLE: flush wins and the start is dropped.
- All arithmetic is modulo 2^DATA_W on the output. Internal accumulators are 2·DATA_W+1 bits wide so nothing overflows.

## Timing
- Cycle 0 is the cycle in which `start` is high in IDLE.
- Normal path:
  - CALC in cycles 1 … DATA_W.
  - FIX in cycle DATA_W+1.
  - DONE in cycle DATA_W+2 (`done` = 1, `result` valid).
  - IDLE in cycle DATA_W+3.
  - Total latency is DATA_W+2 cycles; for DATA_W=32, `done` is in cycle 34.
- Fast path: DONE in cycle 1, and `busy` is never asserted.
- `busy` is a registered decode of the state: 1 in cycles 1 … DATA_W+1, 0 in DONE.
- A new `start` can be accepted in cycle DATA_W+3, the first IDLE cycle; it cannot be accepted in DONE.
- Reset values: FSM in IDLE, `busy` = 0, `done` = 0, `result` = 0, all internal registers = 0.
- Reset mid-operation takes effect immediately and asynchronously; no `done` follows it.

## Test plan
- MUL, `op_a`=7, `op_b`=0xFFFFFFFD (-3), DATA_W=32 → `busy` high in cycles 1–33, `done` in cycle 34, `result`=0xFFFFFFEB. MULHU on 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → `done` in cycle 1 with `result`=0xFFFFFFFF and `busy` never high. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000, cycle 1. REM of the same operands → 0.
- `start` pulsed in cycles 5 and 34 of a running op → both ignored and exactly one `done`. A new `start` in cycle 35 is accepted and its `done` arrives in cycle 69.
- `flush` in cycle 10 → IDLE in cycle 11, no `done`, `result` unchanged. `reset` pulsed mid-CALC → `busy`, `done` and `result` go to 0 immediately, and a subsequent op completes correctly.
